// File: rtl/fn_to_recfn_issue.sv
// Purpose: recodes two IEEE-754 operands into the recoded-float format ahead of an adder issue slot.
// Latency: 1 cycle from accept to out_valid. Backpressure: in_ready follows out_ready when the single
// entry is full; with FN_TO_RECFN_SKID_EN a second entry decouples in_ready from out_ready.
module fn_to_recfn_issue #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    output logic                         in_ready,
    input  logic [expWidth+sigWidth-1:0] a_in,
    input  logic [expWidth+sigWidth-1:0] b_in,
    input  logic                         sub_in,
    input  logic [2:0]                   rm_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [expWidth+sigWidth:0]   a_rec,
    output logic [expWidth+sigWidth:0]   b_rec,
    output logic                         sub_out,
    output logic [2:0]                   rm_out
);
    localparam int fnWidth  = expWidth + sigWidth;
    localparam int recWidth = fnWidth + 1;
    localparam logic [expWidth:0] subBias  = (expWidth+1)'((1 << (expWidth-1)) | 2);
    localparam logic [expWidth:0] normBias = (expWidth+1)'((1 << (expWidth-1)) + 1);

    function automatic logic [expWidth:0] leadZeros(input logic [sigWidth-2:0] f);
        logic [expWidth:0] n;
        n = '0;
        for (int i = 0; i < sigWidth-1; i++)
            if (f[i]) n = (expWidth+1)'(sigWidth - 2 - i);
        return n;
    endfunction

    function automatic logic [recWidth-1:0] recode(input logic [fnWidth-1:0] x);
        logic [expWidth-1:0] e;
        logic [sigWidth-2:0] f;
        logic [sigWidth-1:0] shifted;
        logic [expWidth:0]   nd;
        logic [expWidth:0]   adjExp;
        logic [expWidth:0]   recExp;
        e       = x[fnWidth-2 -: expWidth];
        f       = x[sigWidth-2:0];
        nd      = leadZeros(f);
        shifted = {f, 1'b0} << nd;
        if (e == '0) adjExp = ~nd + subBias;
        else         adjExp = {1'b0, e} + normBias;
        // Zero is canonicalised to an all-zero exponent; its low exponent bits carry no meaning.
        if (&e)                          recExp = {2'b11, |f, adjExp[expWidth-3:0]};
        else if (e == '0 && f == '0)     recExp = '0;
        else                             recExp = adjExp;
        return {x[fnWidth-1], recExp, (e == '0) ? shifted[sigWidth-2:0] : f};
    endfunction

    logic [recWidth-1:0] aRecIn, bRecIn;
    logic [recWidth-1:0] headA, headB;
    logic                headSub;
    logic [2:0]          headRm;
    logic                accept, drain, loadHead;

    assign aRecIn = recode(a_in);
    assign bRecIn = recode(b_in);
    assign accept = go && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef FN_TO_RECFN_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t              state, stateNext;
    logic [recWidth-1:0] aSkid, bSkid;
    logic                subSkid;
    logic [2:0]          rmSkid;
    logic                loadSkid, headFromSkid;

    always_comb begin
        stateNext    = state;
        loadHead     = 1'b0;
        loadSkid     = 1'b0;
        headFromSkid = 1'b0;
        case (state)
            EMPTY: if (accept) begin stateNext = ONE; loadHead = 1'b1; end
            ONE: begin
                if (accept && drain) loadHead = 1'b1;
                else if (accept) begin stateNext = TWO; loadSkid = 1'b1; end
                else if (drain) stateNext = EMPTY;
            end
            TWO: if (drain) begin stateNext = ONE; loadHead = 1'b1; headFromSkid = 1'b1; end
            default: stateNext = EMPTY;
        endcase
    end

    // Ready is decoded from state only, so out_ready never reaches in_ready.
    assign in_ready  = reset && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign headA     = headFromSkid ? aSkid   : aRecIn;
    assign headB     = headFromSkid ? bSkid   : bRecIn;
    assign headSub   = headFromSkid ? subSkid : sub_in;
    assign headRm    = headFromSkid ? rmSkid  : rm_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aSkid   <= '0;
            bSkid   <= '0;
            subSkid <= 1'b0;
            rmSkid  <= '0;
        end else if (loadSkid) begin
            aSkid   <= aRecIn;
            bSkid   <= bRecIn;
            subSkid <= sub_in;
            rmSkid  <= rm_in;
        end
    end
`else
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, stateNext;

    always_comb begin
        stateNext = state;
        loadHead  = 1'b0;
        case (state)
            EMPTY: if (accept) begin stateNext = FULL; loadHead = 1'b1; end
            FULL: begin
                if (accept) loadHead = 1'b1;
                else if (drain) stateNext = EMPTY;
            end
            default: stateNext = EMPTY;
        endcase
    end

    assign in_ready  = reset && ((state == EMPTY) || out_ready);
    assign out_valid = (state == FULL);
    assign headA     = aRecIn;
    assign headB     = bRecIn;
    assign headSub   = sub_in;
    assign headRm    = rm_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_rec   <= '0;
            b_rec   <= '0;
            sub_out <= 1'b0;
            rm_out  <= '0;
        end else if (loadHead) begin
            a_rec   <= headA;
            b_rec   <= headB;
            sub_out <= headSub;
            rm_out  <= headRm;
        end
    end
endmodule

// File: tb/tb_fn_to_recfn_issue.sv
// Bench for fn_to_recfn_issue: queue-based model plus directed vectors; honours FN_TO_RECFN_SKID_EN.
module tb_fn_to_recfn_issue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        out_ready = 1'b0;
    logic        sub_in = 1'b0;
    logic [2:0]  rm_in = 3'd0;
    logic [31:0] a_in = 32'h0;
    logic [31:0] b_in = 32'h0;
    logic        in_ready, out_valid, sub_out;
    logic [2:0]  rm_out;
    logic [32:0] a_rec, b_rec;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fn_to_recfn_issue #(.expWidth(8), .sigWidth(24)) dut (
        .clk(clk), .reset(reset), .go(go), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .rm_in(rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_rec(a_rec), .b_rec(b_rec), .sub_out(sub_out), .rm_out(rm_out)
    );

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
        logic        s;
        logic [2:0]  rm;
    } entry_t;
    entry_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Recoded value from the number's class: exponent rebased so that unbiased 0 maps to 256.
    function automatic logic [32:0] recModel(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        logic [22:0] fr;
        int          p;
        e = x[30:23];
        f = x[22:0];
        p = 0;
        if (e == 8'h00 && f == 23'h0) return {x[31], 32'h0};
        if (e == 8'hFF) return {x[31], 2'b11, f != 23'h0, 6'h0, f};
        if (e != 8'h00) return {x[31], 9'(e) + 9'd129, f};
        for (int i = 0; i < 23; i++) if (f[i]) p = i;
        fr = f << (23 - p);
        return {x[31], 9'(p + 107), fr};
    endfunction

    function automatic logic modelReady();
`ifdef FN_TO_RECFN_SKID_EN
        return reset && (q.size() < 2);
`else
        return reset && (q.size() == 0 || out_ready);
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) q.delete();
        else if (clk) begin
            logic acc;
            acc = go && modelReady();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back({recModel(a_in), recModel(b_in), sub_in, rm_in});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
        end else begin
            check("in_ready", in_ready, modelReady());
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("a_rec", a_rec, q[0].a);
                check("b_rec", b_rec, q[0].b);
                check("sub_out", sub_out, q[0].s);
                check("rm_out", rm_out, q[0].rm);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [8] = '{32'h3F800000, 32'hC0490FDB, 32'h00400000, 32'h007FFFFF,
                                32'h7F7FFFFF, 32'hFF800000, 32'h7F800001, 32'h80000000};

    initial begin
        check("model_one", recModel(32'h3F800000), 33'h080000000);
        check("model_minsub", recModel(32'h00000001), 33'h035800000);
        check("model_sub_top", recModel(32'h00400000), 33'h040800000);
        check("model_qnan", recModel(32'h7FC00000), 33'h0E0400000);
        check("model_negzero", recModel(32'h80000000), 33'h100000000);

        #2 reset = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_a_rec", a_rec, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Test 1: accept on the first edge after reset release
        go = 1'b1; a_in = 32'h3F800000; b_in = 32'h00000000; sub_in = 1'b1; rm_in = 3'd3;
        step();
        go = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_a_rec", a_rec, 33'h080000000);
        check("t1_b_rec", b_rec, 33'h000000000);
        check("t1_sub_rm", {sub_out, rm_out}, 4'b1011);

        // Test 2: simultaneous release and accept
        go = 1'b1; out_ready = 1'b1; a_in = 32'h7F800000; b_in = 32'h7FC00000; sub_in = 1'b0; rm_in = 3'd1;
        step();
        go = 1'b0;
        check("t2_a_rec", a_rec, 33'h0E0400000 ^ 33'h0E0400000 ^ 33'h0C0000000);
        check("t2_b_rec", b_rec, 33'h0E0400000);
        step();
        check("t2_drained", out_valid, 0);

        // Test 3: minimum subnormal, negative on b
        out_ready = 1'b0; go = 1'b1; a_in = 32'h00000001; b_in = 32'h80000001; rm_in = 3'd4;
        step();
        go = 1'b0;
        check("t3_a_rec", a_rec, 33'h035800000);
        check("t3_b_rec", b_rec, 33'h135800000);

        // Test 4: go while full and stalled
        go = 1'b1; a_in = 32'h40000000; b_in = 32'h3F800000;
        #1;
`ifdef FN_TO_RECFN_SKID_EN
        check("t4_in_ready", in_ready, 1);
`else
        check("t4_in_ready", in_ready, 0);
`endif
        step();
        go = 1'b0;
        check("t4_hold_a", a_rec, 33'h035800000);
        check("t4_hold_valid", out_valid, 1);
        out_ready = 1'b1; go = 1'b1;
        step();
        go = 1'b0;
        check("t4_new_a", a_rec, 33'h080800000);
        check("t4_new_b", b_rec, 33'h080000000);
        repeat (3) step();
        check("t4_empty", out_valid, 0);

`ifdef FN_TO_RECFN_SKID_EN
        // Test 5: two-entry buffer fills and releases in order
        out_ready = 1'b0; go = 1'b1; b_in = 32'h0;
        a_in = 32'h3F800000; #1 check("t5_rdy1", in_ready, 1); step();
        a_in = 32'h40000000; #1 check("t5_rdy2", in_ready, 1); step();
        a_in = 32'hBF800000; #1 check("t5_rdy3", in_ready, 0); step();
        go = 1'b0;
        check("t5_head1", a_rec, 33'h080000000);
        out_ready = 1'b1;
        step();
        check("t5_head2", a_rec, 33'h080800000);
        check("t5_valid2", out_valid, 1);
        step();
        check("t5_empty", out_valid, 0);
`endif

        // Streaming with intermittent backpressure
        for (int i = 0; i < 8; i++) begin
            go = 1'b1; a_in = stream[i]; b_in = stream[7-i]; sub_in = i[0]; rm_in = 3'(i);
            out_ready = i[1];
            step();
        end
        go = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("stream_empty", out_valid, 0);

        // Test 6: asynchronous reset while holding an entry
        out_ready = 1'b0; go = 1'b1; a_in = 32'hC0490FDB; b_in = 32'h3F800000; sub_in = 1'b1; rm_in = 3'd7;
        step();
        go = 1'b0;
        check("t6_loaded", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_a_rec", a_rec, 0);
        check("t6_b_rec", b_rec, 0);
        check("t6_sub_rm", {sub_out, rm_out}, 0);
        check("t6_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; go = 1'b1; a_in = 32'h00400000;
        step();
        go = 1'b0;
        check("t6_reaccept", a_rec, 33'h040800000);
        out_ready = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
